hc04_gate_sched: RTL and testbench

Time-multiplexing scheduler that shares one physical 74HC04 inverter gate among several requesters in the cpu74hc04 design. Requesters post W-bit words. A round-robin arbiter grants one requester at a time. The block then pushes the granted word through the shared gate one bit per cycle and returns the W-bit inverted result through a valid/ready response port.

---
 rtl/hc04_gate_sched.sv | 161 ++++++++++++++++
 tb/tb_hc04_gate_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hc04_gate_sched.sv
// hc04_gate_sched
// Shares one physical 74HC04 inverter gate among NREQ requesters. A
// round-robin arbiter grants one W-bit word at a time. The word is then
// serialised LSB first through the external gate (gate_a -> gate_y), and the
// inverted result is returned on a valid/ready response port.
//
// Optional feature: define HC04_GATE_SCHED_SELFTEST_EN to compile in a check
// that compares every returned gate bit against the expected inversion and
// raises a sticky err flag on any mismatch. Without the macro, err is tied
// low and the port list stays the same.
module hc04_gate_sched #(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  input  logic              rsp_ready,
  output logic              busy,
  output logic              gate_a,
  input  logic              gate_y,
  output logic              err
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [KW-1:0]   k_reg;
  logic [W-1:0]    shreg_reg;
  logic [W-1:0]    res_reg;
  logic [IDW-1:0]  id_reg;

  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic            grant_en;
  logic [IDW-1:0]  ptr_next;
  logic [W-1:0]    grant_word;
  logic [W-1:0]    req_word [NREQ];

  // Split the flat request bus into one word per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*W +: W];
    end
  endgenerate

  // Round-robin pick: first pending requester at or above ptr, wrapping at
  // NREQ. Scanning offsets from high to low lets the lowest offset win.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(ptr_reg) + off;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  // A grant is only offered while idle; reset suppresses it so nothing is
  // accepted on a cycle whose edge will discard it anyway.
  assign grant_en   = (state_reg == IDLE) && grant_any && !rst;
  assign grant_word = req_word[grant_idx];
  assign ptr_next   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // One-hot grant strobe, one lane per requester.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_en && (grant_idx == IDW'(gi));
    end
  endgenerate

  // Control FSM: capture on grant, shift one bit per cycle, hold the result
  // until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      k_reg     <= '0;
      shreg_reg <= '0;
      res_reg   <= '0;
      id_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            shreg_reg <= grant_word;
            id_reg    <= grant_idx;
            k_reg     <= '0;
            ptr_reg   <= ptr_next;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          res_reg[k_reg] <= gate_y;
          if (k_reg == KW'(W - 1)) begin
            k_reg     <= '0;
            state_reg <= RESP;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state; response fields read zero outside
  // RESP so a half-built result never leaks onto the bus.
  assign busy      = (state_reg == SHIFT) || (state_reg == RESP);
  assign gate_a    = (state_reg == SHIFT) ? shreg_reg[k_reg] : 1'b0;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_valid ? res_reg : '0;
  assign rsp_id    = rsp_valid ? id_reg : '0;

`ifdef HC04_GATE_SCHED_SELFTEST_EN
  logic err_reg;

  // Sticky flag: any shifted bit that does not come back inverted marks the
  // shared gate as faulty until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if ((state_reg == SHIFT) && (gate_y != ~shreg_reg[k_reg])) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hc04_gate_sched.sv
// Self-checking bench for hc04_gate_sched (NREQ=4, W=8). A transaction-level
// reference tracks, per cycle, which requester should be granted, which bit
// should be on the shared gate and when the inverted word should be offered.
module tb_hc04_gate_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_ready = 1'b0;
  logic              busy;
  logic              gate_a;
  logic              gate_y;
  logic              err;
  logic              stuck = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: transaction in flight, its grant cycle and contents.
  logic         m_free  = 1'b1;
  int           m_gcyc  = 0;
  int           m_id    = 0;
  logic [W-1:0] m_word  = '0;
  logic [W-1:0] m_res   = '0;
  logic         m_err   = 1'b0;
  int           mptr    = 0;
  int           granted = -1;

  // Shared gate: ideal inverter, or output stuck low when faulted.
  assign gate_y = stuck ? 1'b0 : ~gate_a;

  always #5 clk = ~clk;

  hc04_gate_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .gate_a    (gate_a),
    .gate_y    (gate_y),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: inputs were set at the preceding falling edge. Outputs
  // are compared 1ns later, then the reference advances across the edge.
  task automatic cycle();
    int              g;
    int              idx;
    int              ph;
    logic [NREQ-1:0] exp_ready;
    logic            exp_rv;
    logic            exp_busy;
    logic            exp_gate;
    logic            gy;
    #1;
    g = -1;
    if (m_free && !rst) begin
      for (int off = 0; off < NREQ; off++) begin
        idx = (mptr + off) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    ph       = cyc - m_gcyc;
    exp_rv   = !m_free && (ph >= W + 1);
    exp_busy = !m_free && (ph >= 1);
    exp_gate = 1'b0;
    if (!m_free && ph >= 1 && ph <= W) exp_gate = m_word[ph-1];

    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("busy",      32'(busy),      32'(exp_busy));
    chk("gate_a",    32'(gate_a),    32'(exp_gate));
    if (exp_rv) begin
      chk("rsp_data", 32'(rsp_data), 32'(m_res));
      chk("rsp_id",   32'(rsp_id),   32'(m_id));
    end
`ifdef HC04_GATE_SCHED_SELFTEST_EN
    chk("err", 32'(err), 32'(m_err));
`else
    chk("err", 32'(err), 32'd0);
`endif

    granted = -1;
    if (rst) begin
      m_free = 1'b1;
      mptr   = 0;
      m_err  = 1'b0;
    end else if (exp_rv) begin
      if (rsp_ready) m_free = 1'b1;
    end else if (!m_free && ph >= 1 && ph <= W) begin
      gy = stuck ? 1'b0 : ~exp_gate;
      m_res[ph-1] = gy;
      if (gy !== ~m_word[ph-1]) m_err = 1'b1;
    end else if (g >= 0) begin
      m_free  = 1'b0;
      m_gcyc  = cyc;
      m_id    = g;
      m_word  = req_data[g*W +: W];
      m_res   = '0;
      mptr    = (g + 1) % NREQ;
      granted = g;
    end
    @(negedge clk);
    cyc++;
  endtask

  // Run n cycles; a granted requester withdraws its request afterwards.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (granted >= 0) req_valid[granted] = 1'b0;
    end
  endtask

  // One reset cycle, followed by a check that every output reads zero.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_gate_a",    32'(gate_a),    32'd0);
    chk("rst_err",       32'(err),       32'd0);
  endtask

  initial begin
    logic [31:0] r;
    @(negedge clk);

    // Reset state
    do_reset();
    do_reset();

    // Single request 0xA5 from requester 0
    req_data[0*W +: W] = 8'hA5;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    run(12);

    // All four requesters held together: grants 0,1,2,3
    do_reset();
    req_data  = {8'h3C, 8'h0F, 8'hFF, 8'h00};
    req_valid = 4'b1111;
    run(44);

    // Back-pressure: consumer stalls five cycles, requester 1 waits meanwhile
    do_reset();
    req_data[0*W +: W] = 8'h96;
    req_data[1*W +: W] = 8'h71;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    run(1);
    req_valid = 4'b0010;
    run(13);
    rsp_ready = 1'b1;
    run(14);

    // Round-robin wrap: requester 3 first, then 0 ahead of 3 again
    do_reset();
    req_data[3*W +: W] = 8'hC1;
    req_valid = 4'b1000;
    run(1);
    req_data[0*W +: W] = 8'h2E;
    req_data[3*W +: W] = 8'h88;
    req_valid = 4'b1001;
    run(30);

    // Reset while bit 4 is on the gate, then requesters 1 and 2 compete
    do_reset();
    req_data[1*W +: W] = 8'h5C;
    req_valid = 4'b0010;
    run(5);
    do_reset();
    req_data[1*W +: W] = 8'hE7;
    req_data[2*W +: W] = 8'h19;
    req_valid = 4'b0110;
    run(25);

    // Randomised traffic with random consumer stalls
    do_reset();
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          r = $urandom;
          req_data[i*W +: W] = r[W-1:0];
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(2) != 0);
      cycle();
      if (granted >= 0) req_valid[granted] = 1'b0;
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    run(12);

`ifdef HC04_GATE_SCHED_SELFTEST_EN
    // Gate output stuck low while sending 0x01: err latches, data reads 0x00
    do_reset();
    stuck = 1'b1;
    req_data[0*W +: W] = 8'h01;
    req_valid = 4'b0001;
    run(12);
    stuck = 1'b0;
    run(6);
    #1;
    chk("err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
